// File: rtl/cpu_mem_responder.sv
// Memory-side responder: a word-addressed RAM that serves one fetch or data request at a time,
// completing LATENCY edges after acceptance. Define MISALIGN_ERR_EN to flag misaligned accesses on err.
module cpu_mem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [31:0] i_addr,
  input  logic [31:0] d_addr,
  input  logic [31:0] writeData,
  input  logic        memRead,
  input  logic        memWrite,
  output logic [31:0] instruction_out,
  output logic [31:0] memload,
  output logic        i_ready,
  output logic        d_ready,
  output logic        busy
`ifdef MISALIGN_ERR_EN
  ,
  output logic        err
`endif
);

  typedef enum logic [1:0] {IDLE, DATA_WAIT, FETCH_WAIT, DONE} state_t;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_idx;
  logic [31:0]       r_wdata;
  logic              r_we;
  logic [31:0]       r_mem [2**ADDR_W];

  logic w_mem_we;
  logic w_aligned;
  logic w_unused_bits;

`ifdef MISALIGN_ERR_EN
  logic [1:0] r_lsb;
  assign w_aligned = (r_lsb == 2'b00);
`else
  assign w_aligned = 1'b1;
`endif

  // Address bits outside the word index only matter when misalignment is flagged.
  assign w_unused_bits = ^{i_addr[31:ADDR_W+2], i_addr[1:0], d_addr[31:ADDR_W+2], d_addr[1:0]};

  assign w_mem_we = (r_state == DATA_WAIT) && (r_cnt == 4'd0) && r_we && w_aligned;

  // NOTE: the RAM array carries no reset; clearing it would turn the storage into flops.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[r_idx] <= r_wdata;
  end

  // NOTE: sequential state uses non-blocking assignments, so the read of r_mem below sees
  // the pre-store word and a store naturally returns read-before-write data.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state         <= IDLE;
      r_cnt           <= 4'd0;
      r_idx           <= '0;
      r_wdata         <= 32'd0;
      r_we            <= 1'b0;
      instruction_out <= 32'd0;
      memload         <= 32'd0;
      i_ready         <= 1'b0;
      d_ready         <= 1'b0;
      busy            <= 1'b0;
`ifdef MISALIGN_ERR_EN
      r_lsb           <= 2'b00;
      err             <= 1'b0;
`endif
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
`ifdef MISALIGN_ERR_EN
      err     <= 1'b0;
`endif
      unique case (r_state)
        IDLE: begin
          r_cnt <= 4'(LATENCY - 1);
          busy  <= 1'b1;
          if (memRead || memWrite) begin
            r_idx   <= d_addr[ADDR_W+1:2];
            r_wdata <= writeData;
            r_we    <= memWrite;
`ifdef MISALIGN_ERR_EN
            r_lsb   <= d_addr[1:0];
`endif
            r_state <= DATA_WAIT;
          end else begin
            r_idx   <= i_addr[ADDR_W+1:2];
            r_we    <= 1'b0;
`ifdef MISALIGN_ERR_EN
            r_lsb   <= i_addr[1:0];
`endif
            r_state <= FETCH_WAIT;
          end
        end
        DATA_WAIT, FETCH_WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_state <= DONE;
            if (r_state == DATA_WAIT) begin
              d_ready <= 1'b1;
              if (w_aligned) memload <= r_mem[r_idx];
            end else begin
              i_ready <= 1'b1;
              if (w_aligned) instruction_out <= r_mem[r_idx];
            end
`ifdef MISALIGN_ERR_EN
            err <= !w_aligned;
`endif
          end
        end
        // Requests still held by the core during the ready cycle are deliberately not sampled.
        DONE: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/cpu_mem_responder.md
Name: cpu_mem_responder

Overview:
- Memory-side responder for the single-cycle core's instruction-fetch and data ports.
- Owns a word-addressed backing RAM and serves one request at a time with a configurable latency.
- Signals completion with one-cycle i_ready / d_ready pulses and returns instruction_out / memload.
- Sits below top1 and replaces ideal memory, so stall behaviour in the core gets exercised.

Parameters:
- ADDR_W, 10, word-address bits; RAM depth 2**ADDR_W words of 32 bits.
- LATENCY, 2, clock edges from request acceptance to ready assertion; legal range 1..15.

Ports:
- clk  input  1  system clock, rising-edge.
- nrst  input  1  asynchronous active-low reset.
- i_addr  input  32  instruction fetch byte address (pc).
- d_addr  input  32  data byte address (aluOut).
- writeData  input  32  store data.
- memRead  input  1  data load request, level.
- memWrite  input  1  data store request, level.
- instruction_out  output  32  fetched instruction word.
- memload  output  32  loaded data word.
- i_ready  output  1  fetch complete, one-cycle pulse.
- d_ready  output  1  data access complete, one-cycle pulse.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, nrst=0): state=IDLE; i_ready=0, d_ready=0, busy=0, instruction_out=0, memload=0; wait counter=0. RAM contents are not cleared.
- Reset mid-operation aborts the in-flight request. A pending store is discarded, and no ready pulse follows reset release.
- Word index is addr[ADDR_W+1:2]. Bits [1:0] and bits above ADDR_W+1 are ignored, so addresses wrap modulo the RAM size.
- States: IDLE, DATA_WAIT, FETCH_WAIT, DONE.
- IDLE, posedge sample:
  - If memRead|memWrite: latch d_addr, writeData, memWrite; counter<=LATENCY-1; go to DATA_WAIT.
  - Otherwise: latch i_addr; counter<=LATENCY-1; go to FETCH_WAIT.
  - The core always wants a fetch, so IDLE never idles for more than one cycle.
- Priority: data requests win over fetch when both are present in IDLE.
- DATA_WAIT / FETCH_WAIT: if counter!=0, decrement; if counter==0, perform the access and go to DONE.
- Data access with latched memWrite=1: RAM[idx]<=writeData. memload<=old RAM[idx], giving read-before-write data.
- Data access with latched memWrite=0: memload<=RAM[idx].
- Fetch access: instruction_out<=RAM[idx].
- DONE: the matching ready (d_ready or i_ready) is high for exactly this cycle. Next edge goes unconditionally to IDLE without sampling requests. This prevents a repeat access while the core still holds memRead/memWrite during the ready cycle.
- Latency: if the request is sampled at edge N, ready is high from edge N+LATENCY to N+LATENCY+1. Minimum request-to-request spacing is LATENCY+2 edges.
- memRead and memWrite both high: treated as a store (store semantics above).
- Request inputs changing after acceptance have no effect; latched values complete.
- instruction_out and memload hold their last value until the next completion of the same kind.
- i_ready and d_ready are never high in the same cycle.

Optional Feature:
- Macro: MISALIGN_ERR_EN.
- Defined:
  - Adds output port err (1 bit, reset 0).
  - A data access whose latched d_addr[1:0]!=0 suppresses the RAM write and leaves memload unchanged.
  - err is high together with d_ready in DONE.
  - Fetches with i_addr[1:0]!=0 behave the same way, with err high together with i_ready.
- Undefined: no err port; low address bits silently ignored as above.

Test Plan:
- Reset/fetch (LATENCY=2): preload RAM[0]=32'h3E800093, release nrst, i_addr=0. Expect i_ready high exactly 2 edges after the first IDLE sample and instruction_out=32'h3E800093. i_ready then low, busy low for one cycle.
- Store then load: memWrite=1, d_addr=0x40, writeData=0xDEADBEEF; after d_ready, memRead=1, d_addr=0x40. Expect memload=0xDEADBEEF on the second d_ready, and no duplicate store while memWrite is held through DONE.
- Priority: memRead=1 and i_addr=0x8 both present in IDLE. Expect d_ready first, then i_ready on the next transaction; never both high in one cycle.
- Wrap (ADDR_W=10): store 0x12345678 at d_addr=0x1000, then load d_addr=0x0. Expect memload=0x12345678.
- Reset mid-op: assert nrst=0 during DATA_WAIT of a store to 0x80. Expect all outputs 0 immediately, RAM[0x20] unchanged, and no d_ready after release.
- LATENCY=1 sweep: back-to-back fetches at i_addr 0,4,8. Expect i_ready period of exactly 3 cycles.
